mem_arbiter: RTL

Shares the single memory port between instruction fetch (IFU) and load/store (LSU) once the core moves from the combinational `inst`/`rdata` hookup to a request/response memory. Sits between the core top and the memory model/bus. Carries one outstanding transaction at a time. Uses 2-way round-robin grant and routes the response back to the owner.

---
 rtl/npc_mem_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 20 ++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/npc_mem_pkg.sv
// Shared types and constants for the fetch/load-store memory arbiter.
// States, owner encoding and store-length codes used by the arbiter and its bench.
package npc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam logic [3:0] WLEN_B = 4'd1;
    localparam logic [3:0] WLEN_H = 4'd2;
    localparam logic [3:0] WLEN_W = 4'd4;
    localparam logic [3:0] WLEN_D = 4'd8;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick: one-hot grant, favouring the requester
// that was not served last. Bit 0 is IFU, bit 1 is LSU.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    // i_last = 1 means LSU was served last, so a tie goes to IFU
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one request/response memory port between instruction fetch and
// load/store, one outstanding transaction at a time, round-robin on ties.
module mem_arbiter
    import npc_mem_pkg::*;
#(
    parameter int DW = 64,
    parameter int AW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_rsp_valid,
    output logic [31:0]   ifu_rdata,
    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic [AW-1:0] lsu_addr,
    input  logic          lsu_wen,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [3:0]    lsu_wlen,
    output logic          lsu_rsp_valid,
    output logic [DW-1:0] lsu_rdata,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_ren,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_wlen,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rdata
);

    state_t        r_state;
    state_t        w_state_nxt;
    owner_t        r_owner;
    owner_t        r_last;
    logic [AW-1:0] r_addr;
    logic          r_ren;
    logic          r_wen;
    logic [DW-1:0] r_wdata;
    logic [3:0]    r_wlen;
    logic [1:0]    w_req;
    logic [1:0]    w_gnt;
    logic          w_last_lsu;
    logic          w_rsp;

    assign w_req      = {lsu_req_valid, ifu_req_valid};
    assign w_last_lsu = (r_last == OWN_LSU);

    rr_arb2 u_rr_arb2 (
        .i_req  (w_req),
        .i_last (w_last_lsu),
        .o_gnt  (w_gnt)
    );

    // Handshakes are masked during reset so nothing is accepted or answered and then lost
    always_comb begin
        w_state_nxt   = r_state;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        w_rsp         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ifu_req_ready = w_gnt[0] & ~rst;
                lsu_req_ready = w_gnt[1] & ~rst;
                if (|w_gnt) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    w_rsp       = ~rst;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_IFU;
            r_last  <= OWN_LSU;
        end else begin
            r_state <= w_state_nxt;
            if (ifu_req_ready | lsu_req_ready) begin
                r_owner <= lsu_req_ready ? OWN_LSU : OWN_IFU;
                r_last  <= lsu_req_ready ? OWN_LSU : OWN_IFU;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wlen  <= '0;
        end else if (ifu_req_ready) begin
            r_addr  <= ifu_addr;
            r_ren   <= 1'b1;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wlen  <= '0;
        end else if (lsu_req_ready) begin
            r_addr  <= lsu_addr;
            r_ren   <= ~lsu_wen;
            r_wen   <= lsu_wen;
            r_wdata <= lsu_wdata;
            r_wlen  <= lsu_wlen;
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wlen  = r_wlen;
    assign mem_ren   = mem_req_valid & r_ren;
    assign mem_wen   = mem_req_valid & r_wen;

    assign ifu_rsp_valid = w_rsp & (r_owner == OWN_IFU);
    assign lsu_rsp_valid = w_rsp & (r_owner == OWN_LSU);

    // The fetch word is the half of the 64-bit beat selected by address bit 2
    assign ifu_rdata = ifu_rsp_valid ? (r_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0]) : 32'd0;
    assign lsu_rdata = (lsu_rsp_valid & r_ren) ? mem_rdata : '0;

endmodule
